// File: rtl/coin_change_dispenser.sv
// Change-return payout controller: turns a change amount into a greedy sequence of
// coin-eject requests while tracking per-denomination hopper stock and reporting shortfall.
module coin_change_dispenser #(
  parameter int AMT_W   = 4,
  parameter int STOCK_W = 4,
  parameter int INIT_5  = 3,
  parameter int INIT_2  = 5,
  parameter int INIT_1  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AMT_W-1:0]   amount,
  input  logic               coin_ack,
  input  logic               refill,
  output logic [1:0]         coin_out,
  output logic               coin_valid,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [AMT_W-1:0]   shortfall,
  output logic [STOCK_W-1:0] stock5,
  output logic [STOCK_W-1:0] stock2,
  output logic [STOCK_W-1:0] stock1
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE, S_FAULT} state_t;

  localparam logic [1:0] COIN_1 = 2'd1;
  localparam logic [1:0] COIN_2 = 2'd2;
  localparam logic [1:0] COIN_5 = 2'd3;

  state_t             state, state_nxt;
  logic [AMT_W-1:0]   rem, rem_nxt, shortfall_nxt, coin_val;
  logic [1:0]         pick, coin_out_nxt;
  logic               coin_valid_nxt, busy_nxt, done_nxt, fault_nxt;
  logic [STOCK_W-1:0] stock5_nxt, stock2_nxt, stock1_nxt;

  // Greedy denomination choice with fallback to smaller coins; 0 means nothing payable.
  always_comb begin
    pick = 2'd0;
    if (rem >= AMT_W'(5) && stock5 != '0)      pick = COIN_5;
    else if (rem >= AMT_W'(2) && stock2 != '0) pick = COIN_2;
    else if (stock1 != '0)                     pick = COIN_1;
  end

  always_comb begin
    case (coin_out)
      COIN_5:  coin_val = AMT_W'(5);
      COIN_2:  coin_val = AMT_W'(2);
      COIN_1:  coin_val = AMT_W'(1);
      default: coin_val = '0;
    endcase
  end

  // State register; outputs and datapath are registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rem        <= '0;
      coin_out   <= '0;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      shortfall  <= '0;
      stock5     <= STOCK_W'(INIT_5);
      stock2     <= STOCK_W'(INIT_2);
      stock1     <= STOCK_W'(INIT_1);
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      coin_out   <= coin_out_nxt;
      coin_valid <= coin_valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      fault      <= fault_nxt;
      shortfall  <= shortfall_nxt;
      stock5     <= stock5_nxt;
      stock2     <= stock2_nxt;
      stock1     <= stock1_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SELECT;
      S_SELECT: begin
        if (rem == '0)        state_nxt = S_DONE;
        else if (pick != '0)  state_nxt = S_ISSUE;
        else                  state_nxt = S_FAULT;
      end
      S_ISSUE:  if (coin_ack) state_nxt = S_SELECT;
      S_DONE:   state_nxt = S_IDLE;
      S_FAULT:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    coin_out_nxt   = coin_out;
    coin_valid_nxt = coin_valid;
    busy_nxt       = (state_nxt != S_IDLE);
    done_nxt       = 1'b0;
    fault_nxt      = 1'b0;
    rem_nxt        = rem;
    shortfall_nxt  = shortfall;
    stock5_nxt     = stock5;
    stock2_nxt     = stock2;
    stock1_nxt     = stock1;
    case (state)
      S_IDLE: begin
        if (start) begin
          rem_nxt       = amount;
          shortfall_nxt = '0;
        end else if (refill) begin
          stock5_nxt = STOCK_W'(INIT_5);
          stock2_nxt = STOCK_W'(INIT_2);
          stock1_nxt = STOCK_W'(INIT_1);
        end
      end
      S_SELECT: begin
        if (rem == '0) begin
          done_nxt = 1'b1;
        end else if (pick != '0) begin
          coin_out_nxt   = pick;
          coin_valid_nxt = 1'b1;
        end else begin
          shortfall_nxt = rem;
          fault_nxt     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (coin_ack) begin
          coin_out_nxt   = '0;
          coin_valid_nxt = 1'b0;
          rem_nxt        = rem - coin_val;
          case (coin_out)
            COIN_5:  stock5_nxt = stock5 - 1'b1;
            COIN_2:  stock2_nxt = stock2 - 1'b1;
            COIN_1:  stock1_nxt = stock1 - 1'b1;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Randomized scoreboard bench for coin_change_dispenser with a greedy payout reference model.
module tb_coin_change_dispenser;

  typedef struct {
    int kind;  // 0 coin, 1 done, 2 fault
    int val;   // coin code, or expected shortfall
    int s5;
    int s2;
    int s1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] amount = '0;
  logic       coin_ack = 1'b0;
  logic       refill = 1'b0;
  logic [1:0] coin_out;
  logic       coin_valid, busy, done, fault;
  logic [3:0] shortfall, stock5, stock2, stock1;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m5 = 3, m2 = 5, m1 = 5, m_sf = 0;
  int   ack_dly = 1;
  bit   ack_rand = 1'b0;
  bit   ack_en = 1'b1;
  bit   prev_v = 1'b0;
  int   held = 0;

  coin_change_dispenser dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .coin_ack(coin_ack),
    .refill(refill), .coin_out(coin_out), .coin_valid(coin_valid), .busy(busy),
    .done(done), .fault(fault), .shortfall(shortfall),
    .stock5(stock5), .stock2(stock2), .stock1(stock1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int val);
    exp_t e;
    e.kind = kind; e.val = val; e.s5 = m5; e.s2 = m2; e.s1 = m1;
    q.push_back(e);
  endtask

  // Reference: pay greedily from the largest affordable coin that is in stock.
  task automatic model_pay(input int a);
    int rem = a;
    m_sf = 0;
    while (rem > 0) begin
      if (rem >= 5 && m5 > 0)      begin push(0, 3); m5--; rem -= 5; end
      else if (rem >= 2 && m2 > 0) begin push(0, 2); m2--; rem -= 2; end
      else if (m1 > 0)             begin push(0, 1); m1--; rem -= 1; end
      else break;
    end
    if (rem == 0) push(1, 0);
    else begin m_sf = rem; push(2, rem); end
  endtask

  task automatic model_reload();
    m5 = 3; m2 = 5; m1 = 5;
  endtask

  task automatic pop_check(input int kind, input int val, input bit stocks);
    exp_t e;
    if (q.size() == 0) begin
      check("unexpected_event", kind, -1);
    end else begin
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      check(kind == 0 ? "coin_code" : "shortfall", val, e.val);
      if (stocks) begin
        check("stock5", int'(stock5), e.s5);
        check("stock2", int'(stock2), e.s2);
        check("stock1", int'(stock1), e.s1);
      end
    end
  endtask

  // Monitor: compares every presented coin and every done/fault pulse against the queue.
  always @(negedge clk) begin
    if (coin_valid) begin
      if (!prev_v) pop_check(0, int'(coin_out), 1'b0);
      else         check("coin_stable", int'(coin_out), held);
      held = int'(coin_out);
    end
    if (done)  pop_check(1, int'(shortfall), 1'b1);
    if (fault) pop_check(2, int'(shortfall), 1'b1);
    prev_v = coin_valid;
  end

  // Hopper: acknowledges each presented coin after a delay; occasional stray acks while idle.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (ack_en && coin_valid && !rst) begin
        d = ack_rand ? int'($urandom_range(0, 4)) : ack_dly;
        repeat (d) @(negedge clk);
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
      end else if (ack_en && !busy && $urandom_range(0, 7) == 0) begin
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
      end
    end
  end

  task automatic start_pay(input int a, input bit rf);
    @(negedge clk);
    start = 1'b1; amount = 4'(a); refill = rf;
    model_pay(a);
    @(negedge clk);
    start = 1'b0; refill = 1'b0;
  endtask

  task automatic wait_idle(input bit poke);
    int k = 0;
    while (busy && k < 400) begin
      @(negedge clk); k++;
      if (poke && busy && $urandom_range(0, 4) == 0) begin
        start = 1'b1; amount = 4'($urandom_range(0, 15)); refill = 1'($urandom_range(0, 1));
        @(negedge clk); k++;
        start = 1'b0; refill = 1'b0;
      end
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic do_pay(input int a);
    start_pay(a, 1'b0);
    wait_idle(1'b0);
  endtask

  task automatic do_refill();
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    model_reload();
    check("refill_stock5", int'(stock5), m5);
    check("refill_stock2", int'(stock2), m2);
    check("refill_stock1", int'(stock1), m1);
    check("refill_shortfall", int'(shortfall), m_sf);
  endtask

  initial begin
    int k;
    #12;
    check("rst_coin_out", int'(coin_out), 0);
    check("rst_coin_valid", int'(coin_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_shortfall", int'(shortfall), 0);
    check("rst_stock5", int'(stock5), 3);
    check("rst_stock2", int'(stock2), 5);
    check("rst_stock1", int'(stock1), 5);
    @(negedge clk); rst = 1'b0;

    do_pay(8);
    check("busy_after_8", int'(busy), 0);

    start_pay(0, 1'b0);
    check("zero_done_early", int'(done), 0);
    @(negedge clk);
    check("zero_done_at_2", int'(done), 1);
    wait_idle(1'b0);

    ack_dly = 4;
    do_pay(7);
    ack_dly = 1;

    do_refill();
    do_pay(15);
    do_pay(10);
    do_pay(3);
    do_pay(4);
    check("deplete_shortfall", int'(shortfall), 2);
    do_refill();
    start_pay(1, 1'b0);
    check("shortfall_cleared", int'(shortfall), 0);
    wait_idle(1'b0);

    // Mid-payout start/refill pokes must be ignored.
    ack_dly = 3;
    start_pay(13, 1'b0);
    wait_idle(1'b1);

    ack_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) do_refill();
      start_pay(int'($urandom_range(0, 15)), k == 1);
      wait_idle(1'b1);
    end

    // Reset while a coin is being presented.
    do_refill();
    ack_en = 1'b0;
    start_pay(9, 1'b0);
    k = 0;
    while (!coin_valid && k < 20) begin @(negedge clk); k++; end
    check("issue_reached", int'(coin_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_coin_valid", int'(coin_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_stock5", int'(stock5), 3);
    check("arst_stock2", int'(stock2), 5);
    check("arst_stock1", int'(stock1), 5);
    q.delete();
    model_reload();
    m_sf = 0;
    @(negedge clk); rst = 1'b0;
    ack_en = 1'b1;
    do_pay(6);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
